// File: rtl/adder_multicycle_nb_pkg.sv
// Shared types and sizing helpers for the multi-cycle adder/subtractor.
package adder_multicycle_nb_pkg;

   // Controller states: waiting for a request, adding chunks, holding a result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of chunk-add cycles needed for one operation.
   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Chunk counter width; kept at least one bit so a single-chunk build still has a counter.
   function automatic int cnt_width(input int width, input int chunk);
      int n;
      n = width / chunk;
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adder_multicycle_nb_if.sv
// Request/response handshake bundle for the multi-cycle adder/subtractor.
// "master" is the requester/consumer side, "slave" is the adder itself.
interface adder_multicycle_nb_if #(
   parameter int WIDTH = 32
);
   logic             req_val;
   logic             req_rdy;
   logic [WIDTH-1:0] req_in0;
   logic [WIDTH-1:0] req_in1;
   logic             req_sub;
   logic             resp_val;
   logic             resp_rdy;
   logic [WIDTH-1:0] resp_sum;
   logic             resp_cout;
   logic             resp_ovf;

   modport master (
      output req_val, req_in0, req_in1, req_sub, resp_rdy,
      input  req_rdy, resp_val, resp_sum, resp_cout, resp_ovf
   );

   modport slave (
      input  req_val, req_in0, req_in1, req_sub, resp_rdy,
      output req_rdy, resp_val, resp_sum, resp_cout, resp_ovf
   );
endinterface

// File: rtl/adder_multicycle_nb_chunk.sv
// Combinational CHUNK-bit adder with carry in and carry out.
// This is the only arithmetic unit in the block; the top reuses it every cycle.
module adder_chunk_nb #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   // One extra bit on each operand captures the carry out of the chunk MSB.
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/adder_multicycle_nb.sv
// Multi-cycle WIDTH-bit adder/subtractor: adds CHUNK bits per cycle through one
// chunk adder with a registered carry, then holds sum, carry-out and signed
// overflow until the consumer takes them.
module adder_multicycle_nb
   import adder_multicycle_nb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   adder_multicycle_nb_if.slave bus
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int CNT_W  = cnt_width(WIDTH, CHUNK);

   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Latched operands; op_b already holds ~B for a subtract.
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [WIDTH-1:0] sum_acc;

   // Registered handshake and result outputs.
   logic             req_rdy_q;
   logic             resp_val_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   // Current chunk slice and adder results.
   logic [31:0]      base;
   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK-1:0] s_chunk;
   logic             c_chunk;
   logic [WIDTH-1:0] sum_next;
   logic             last;
   logic             ovf_next;

   // Bit offset of the chunk being processed this cycle.
   assign base = 32'(cnt) * 32'(CHUNK);

   // Shifts rather than indexed part-selects keep the select logic width-agnostic.
   assign a_chunk = CHUNK'(op_a >> base);
   assign b_chunk = CHUNK'(op_b >> base);

   adder_chunk_nb #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry),
      .sum  (s_chunk),
      .cout (c_chunk)
   );

   assign last = (cnt == LAST_CNT);

   // Merge this cycle's chunk result into the running sum.
   always_comb begin
      sum_next = sum_acc;
      sum_next = (sum_next & ~(CHUNK_MASK << base)) | (WIDTH'(s_chunk) << base);
   end

   // On the final chunk s_chunk's MSB is the sum MSB; overflow when like-signed
   // operands produce a result of the other sign.
   assign ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (s_chunk[CHUNK-1] != op_a[WIDTH-1]);

   // Controller, counter, operand/sum registers and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         carry      <= 1'b0;
         sum_acc    <= '0;
         req_rdy_q  <= 1'b1;
         resp_val_q <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_val) begin
                  op_a      <= bus.req_in0;
                  op_b      <= bus.req_sub ? ~bus.req_in1 : bus.req_in1;
                  // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                  carry     <= bus.req_sub;
                  sum_acc   <= '0;
                  cnt       <= '0;
                  req_rdy_q <= 1'b0;
                  state     <= CALC;
               end
            end
            CALC: begin
               sum_acc <= sum_next;
               carry   <= c_chunk;
               cnt     <= cnt + 1'b1;
               if (last) begin
                  sum_q      <= sum_next;
                  cout_q     <= c_chunk;
                  ovf_q      <= ovf_next;
                  resp_val_q <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               // No accept in the same cycle as the response leaves.
               if (bus.resp_rdy) begin
                  resp_val_q <= 1'b0;
                  req_rdy_q  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               resp_val_q <= 1'b0;
               req_rdy_q  <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_rdy   = req_rdy_q;
   assign bus.resp_val  = resp_val_q;
   assign bus.resp_sum  = sum_q;
   assign bus.resp_cout = cout_q;
   assign bus.resp_ovf  = ovf_q;

endmodule

// File: tb/tb_adder_multicycle_nb.sv
// Bench for adder_multicycle_nb: directed vector table, backpressure and
// mid-operation reset on a 32/8 instance, then a random sweep over other shapes.
`timescale 1ns/1ps
module tb_adder_multicycle_nb;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int n_checks       = 0;
   int n_pass         = 0;
   bit sweep_go       = 1'b0;
   int sweep_finished = 0;

   adder_multicycle_nb_if #(.WIDTH(32)) bus();

   adder_multicycle_nb #(.WIDTH(32), .CHUNK(8)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference {ovf, cout, sum} from plain integer arithmetic on w-bit operands.
   function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic sub);
      longint ua, ub, r, sa, sb, sr, full, half;
      logic [31:0] s;
      logic c, v;
      full = longint'(1) << w;
      half = full >> 1;
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = sub ? ua - ub : ua + ub;
      s  = 32'(r & (full - 1));
      c  = sub ? (ua >= ub) : (r >= full);
      sa = a[w-1] ? ua - full : ua;
      sb = b[w-1] ? ub - full : ub;
      sr = sub ? sa - sb : sa + sb;
      v  = (sr >= half) || (sr < -half);
      return {v, c, s};
   endfunction

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t        vecs[8];
   logic [33:0] sb_q[$];

   // Issue one request on the 32/8 instance and check latency, busy req_rdy and result.
   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [33:0] exp);
      int lat;
      bit rdy_seen;
      logic [33:0] e;
      check($sformatf("%s idle_rdy", name), 64'(bus.req_rdy), 64'd1);
      bus.req_in0 = a;
      bus.req_in1 = b;
      bus.req_sub = sub;
      bus.req_val = 1'b1;
      sb_q.push_back(exp);
      @(posedge clk);
      @(negedge clk);
      bus.req_val = 1'b0;
      // Operand changes after accept must not matter.
      bus.req_in0 = $urandom;
      bus.req_in1 = $urandom;
      bus.req_sub = ~sub;
      lat = 0;
      rdy_seen = 1'b0;
      while (!bus.resp_val && lat < 100) begin
         if (bus.req_rdy) rdy_seen = 1'b1;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      if (bus.req_rdy) rdy_seen = 1'b1;
      check($sformatf("%s resp_val", name), 64'(bus.resp_val), 64'd1);
      check($sformatf("%s latency", name), 64'(lat), 64'd4);
      check($sformatf("%s busy_rdy", name), 64'(rdy_seen), 64'd0);
      e = sb_q.pop_front();
      check($sformatf("%s result", name), 64'({bus.resp_ovf, bus.resp_cout, bus.resp_sum}), 64'(e));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s released", name), 64'(bus.resp_val), 64'd0);
   endtask

   initial begin
      int lat;
      bit bad;
      logic [33:0] e;
      bus.req_val  = 1'b0;
      bus.req_in0  = '0;
      bus.req_in1  = '0;
      bus.req_sub  = 1'b0;
      bus.resp_rdy = 1'b1;

      vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
      vecs[7] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0};

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset req_rdy",   64'(bus.req_rdy),   64'd1);
      check("reset resp_val",  64'(bus.resp_val),  64'd0);
      check("reset resp_sum",  64'(bus.resp_sum),  64'd0);
      check("reset resp_cout", 64'(bus.resp_cout), 64'd0);
      check("reset resp_ovf",  64'(bus.resp_ovf),  64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                {vecs[i].ovf, vecs[i].cout, vecs[i].sum});

      // Backpressure: result held for 5 stalled cycles, competing request refused.
      bus.resp_rdy = 1'b0;
      check("bp idle_rdy", 64'(bus.req_rdy), 64'd1);
      bus.req_in0 = 32'd10;
      bus.req_in1 = 32'd20;
      bus.req_sub = 1'b0;
      bus.req_val = 1'b1;
      sb_q.push_back({1'b0, 1'b0, 32'd30});
      @(posedge clk);
      @(negedge clk);
      bus.req_val = 1'b0;
      lat = 0;
      while (!bus.resp_val && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check("bp latency", 64'(lat), 64'd4);
      e = sb_q.pop_front();
      check("bp result", 64'({bus.resp_ovf, bus.resp_cout, bus.resp_sum}), 64'(e));
      bus.req_in0 = 32'h1111;
      bus.req_in1 = 32'h2222;
      bus.req_val = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("bp stall%0d val", i), 64'(bus.resp_val), 64'd1);
         check($sformatf("bp stall%0d rdy", i), 64'(bus.req_rdy), 64'd0);
         check($sformatf("bp stall%0d hold", i),
               64'({bus.resp_ovf, bus.resp_cout, bus.resp_sum}), 64'(e));
      end
      bus.req_val  = 1'b0;
      bus.resp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_rdy = 1'b0;
      check("bp after val", 64'(bus.resp_val), 64'd0);
      check("bp after rdy", 64'(bus.req_rdy), 64'd1);
      check("bp retained",  64'({bus.resp_ovf, bus.resp_cout, bus.resp_sum}), 64'(e));
      repeat (2) @(negedge clk);
      check("bp refused stays idle", 64'(bus.req_rdy), 64'd1);
      bus.resp_rdy = 1'b1;

      // Reset two cycles into CALC aborts the operation immediately.
      bus.req_in0 = 32'h1234_5678;
      bus.req_in1 = 32'h0000_0001;
      bus.req_sub = 1'b0;
      bus.req_val = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_val = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort req_rdy",  64'(bus.req_rdy),  64'd1);
      check("abort resp_val", 64'(bus.resp_val), 64'd0);
      check("abort outputs",  64'({bus.resp_ovf, bus.resp_cout, bus.resp_sum}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.resp_val) bad = 1'b1;
      end
      check("abort no response", 64'(bad), 64'd0);
      run_op("after_reset", 32'd3, 32'd4, 1'b0, {1'b0, 1'b0, 32'd7});

      sweep_go = 1'b1;
      for (int t = 0; t < 20000 && sweep_finished < 4; t++) @(negedge clk);
      check("sweep complete", 64'(sweep_finished), 64'd4);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   function automatic int sweep_w(input int g);
      return (g == 3) ? 16 : 32;
   endfunction

   function automatic int sweep_c(input int g);
      case (g)
         0:       return 1;
         1:       return 4;
         2:       return 32;
         default: return 4;
      endcase
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_sweep
      localparam int SW = sweep_w(g);
      localparam int SC = sweep_c(g);
      localparam int SN = SW / SC;

      adder_multicycle_nb_if #(.WIDTH(SW)) sif();

      adder_multicycle_nb #(.WIDTH(SW), .CHUNK(SC)) sdut (
         .clk   (clk),
         .reset (rst_n),
         .bus   (sif.slave)
      );

      logic [33:0] sq[$];

      initial begin
         logic [31:0] a, b, mask;
         logic        s;
         int          lat;
         logic [33:0] e;
         mask = (SW == 32) ? 32'hFFFF_FFFF : ((32'd1 << SW) - 32'd1);
         sif.req_val  = 1'b0;
         sif.req_in0  = '0;
         sif.req_in1  = '0;
         sif.req_sub  = 1'b0;
         sif.resp_rdy = 1'b1;
         wait (sweep_go);
         for (int i = 0; i < 30; i++) begin
            a = $urandom & mask;
            b = $urandom & mask;
            s = (i >= 15);
            if (i == 0) begin
               a = mask;
               b = 32'd1;
            end
            @(negedge clk);
            check($sformatf("sweep w%0d c%0d #%0d rdy", SW, SC, i), 64'(sif.req_rdy), 64'd1);
            sif.req_in0 = a[SW-1:0];
            sif.req_in1 = b[SW-1:0];
            sif.req_sub = s;
            sif.req_val = 1'b1;
            sq.push_back(model(SW, a, b, s));
            @(posedge clk);
            @(negedge clk);
            sif.req_val = 1'b0;
            lat = 0;
            while (!sif.resp_val && lat < 200) begin
               @(posedge clk);
               @(negedge clk);
               lat++;
            end
            check($sformatf("sweep w%0d c%0d #%0d latency", SW, SC, i), 64'(lat), 64'(SN));
            e = sq.pop_front();
            check($sformatf("sweep w%0d c%0d #%0d a=%0h b=%0h sub=%0d", SW, SC, i, a, b, s),
                  64'({sif.resp_ovf, sif.resp_cout, 32'(sif.resp_sum)}), 64'(e));
            @(posedge clk);
         end
         sweep_finished++;
      end
   end

endmodule

// File: doc/adder_multicycle_nb.md
Name: adder_multicycle_nb

Overview:
Parametrised multi-cycle adder/subtractor. Processes WIDTH-bit operands CHUNK bits per cycle through a single chunk adder, with a registered carry between chunks. Reports sum, carry-out and signed overflow. Uses a val/rdy request/response handshake, so the datapath can trade area for latency in the TinyRV1 ALU and address-generation paths.

Parameters:
WIDTH, 32, operand and sum width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH; NCHUNK = WIDTH/CHUNK.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
req_val  in  1  request valid
req_rdy  out  1  block can accept a request
req_in0  in  WIDTH  operand A
req_in1  in  WIDTH  operand B
req_sub  in  1  0 = A+B, 1 = A-B
resp_val  out  1  result valid
resp_rdy  in  1  consumer accepts result
resp_sum  out  WIDTH  result, modulo 2^WIDTH
resp_cout  out  1  carry-out of MSB (for subtract: 1 = no borrow)
resp_ovf  out  1  two's-complement signed overflow

Behaviour:
- States: IDLE, CALC, DONE. Reset (reset low, asynchronous) forces IDLE, chunk counter = 0 and all data registers = 0.
- Reset values: req_rdy=1 (IDLE), resp_val=0, resp_sum=0, resp_cout=0, resp_ovf=0.
- IDLE: req_rdy=1. On req_val && req_rdy:
  - latch A = req_in0.
  - latch B = req_sub ? ~req_in1 : req_in1.
  - carry register = req_sub.
  - clear sum register; counter = 0; go to CALC.
- CALC: req_rdy=0, resp_val=0. Each cycle:
  - chunk k = counter: sum[k*CHUNK +: CHUNK] = A_k + B_k + carry.
  - carry <= chunk carry-out; counter++.
  - On the cycle processing k = NCHUNK-1, go to DONE.
  - Also capture resp_cout = final carry and resp_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the possibly inverted operand.
- Latency: request accepted at edge E; resp_val=1 from edge E+NCHUNK. NCHUNK=4 gives 4 cycles; CHUNK=WIDTH gives 1 cycle.
- DONE: resp_val=1; resp_sum/cout/ovf stable and held while resp_rdy=0. req_rdy=0 (no overlap). On resp_val && resp_rdy, go to IDLE.
- Throughput: at most one request per NCHUNK+2 cycles (accept, NCHUNK calc, response); no bypass from DONE directly to accept.
- resp_sum, resp_cout and resp_ovf are registered. They retain their last values in IDLE until the next result is written.
- Inputs are sampled only at accept. Changes to req_in* or req_sub during CALC or DONE have no effect.
- Wrap-around: sum is truncated to WIDTH bits; the carry is reported only via resp_cout.
- Reset asserted mid-CALC or in DONE aborts the operation: IDLE and zeroed outputs in the same cycle (asynchronous). No response is produced for the aborted request.
- req_val while not in IDLE is ignored; the requester must hold it until req_rdy.

Decomposition:
- Shared package: state enum (IDLE, CALC, DONE) and a helper constant function for NCHUNK and the counter width $clog2(NCHUNK) (min 1).
- Sub-module adder_chunk_nb: combinational CHUNK-bit adder with cin and cout. It is the only arithmetic in the block. The top holds the FSM, counter, operand registers and sum register.

Test Plan:
- Basic add, WIDTH=32 CHUNK=8: A=1, B=1, sub=0, resp_rdy=1 -> resp_val exactly 4 cycles after accept; sum=2, cout=0, ovf=0; req_rdy low during CALC/DONE.
- Carry ripple across chunks: A=0xFFFFFFFF, B=1 -> sum=0, cout=1, ovf=0. A=0x7FFFFFFF, B=1 -> sum=0x80000000, cout=0, ovf=1. A=0x80000000, B=0x80000000 -> sum=0, cout=1, ovf=1.
- Subtract: A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. A=0x80000000, B=1, sub=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold resp_rdy=0 for 5 cycles after resp_val -> outputs stable, req_rdy=0, then one resp_rdy pulse returns to IDLE. A new request accepted during the stall is refused (req_rdy=0).
- Reset mid-op: assert reset 2 cycles into CALC -> outputs zero and req_rdy=1 immediately. After release, A=3, B=4 -> sum=7 with normal latency.
- Parameter sweep: CHUNK in {1,4,32}, WIDTH=32, plus WIDTH=16 CHUNK=4, with 15 random operand pairs each for add and sub -> match the A±B reference model mod 2^WIDTH; latency = WIDTH/CHUNK.
